// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared BCD digit type and active-high seven-segment patterns
package stopwatch_pkg;
  typedef logic [3:0] bcd_digit_t;
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;
endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: BCD nibble to active-high {g..a} pattern, dash plus invalid flag above 9
module bcd_to_seg
  import stopwatch_pkg::*;
(
  input  bcd_digit_t  bcd_i,
  output logic        valid_o,
  output logic [6:0]  seg_o
);
  // pure lookup; blanking and polarity are the scanner's job
  always_comb begin
    valid_o = bcd_i <= 4'd9;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: tear-free multiplexed seven-segment driver for a packed-BCD number bus
module seven_seg_scanner
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS    = 2,
  parameter int SCAN_DIV      = 50000,
  parameter int BLANK_CYCLES  = 2,
  parameter int ACTIVE_LOW    = 1,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] number,
  input  logic                    clear_err,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done,
  output logic                    bcd_error
);
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]   shadow_q, shadow_d;
  logic [6:0]                seg_q, seg_d;
  logic [NUM_DIGITS-1:0]     sel_q, sel_d;
  logic                      fd_q, fd_d, err_q, err_d;
  bcd_digit_t                cur;
  logic                      cur_valid, lead_zero, slot_end, last_idx, frame_end, lit;
  logic [6:0]                cur_seg;
  bcd_to_seg u_dec (
    .bcd_i   (cur),
    .valid_o (cur_valid),
    .seg_o   (cur_seg)
  );
  // scan position, frame snapshot and next output image, all from the current registered state
  always_comb begin
    cur       = shadow_q[4*idx_q +: 4];
    lead_zero = BLANK_LEADING != 0 && idx_q != '0 && (shadow_q >> (4*idx_q)) == '0;
    slot_end  = cnt_q == CW'(SCAN_DIV-1);
    last_idx  = idx_q == IW'(NUM_DIGITS-1);
    frame_end = enable && slot_end && last_idx;
    lit       = enable && cnt_q >= CW'(BLANK_CYCLES);
    cnt_d     = !enable ? cnt_q : slot_end ? '0 : cnt_q + 1'b1;
    idx_d     = !(enable && slot_end) ? idx_q : last_idx ? '0 : idx_q + 1'b1;
    shadow_d  = frame_end ? number : shadow_q;
    sel_d     = lit ? NUM_DIGITS'(1) << idx_q : '0;
    seg_d     = lit && !lead_zero ? cur_seg : SEG_OFF;
    fd_d      = frame_end;
    err_d     = (lit && !cur_valid) || (err_q && !clear_err);
  end
  // state and output registers; reset leaves the display dark at scan position 0
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      seg_q    <= SEG_OFF;
      sel_q    <= '0;
      fd_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      sel_q    <= sel_d;
      fd_q     <= fd_d;
      err_q    <= err_d;
    end
  end
  assign seg        = ACTIVE_LOW != 0 ? ~seg_q : seg_q;
  assign digit_sel  = ACTIVE_LOW != 0 ? ~sel_q : sel_q;
  assign dp         = ACTIVE_LOW != 0;
  assign frame_done = fd_q;
  assign bcd_error  = err_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed vectors against a position-based display model, both polarities
module tb_seven_seg_scanner;
  localparam int SD = 4;
  localparam int BL = 1;
  localparam int ND = 2;
  localparam logic [6:0] PAT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  logic clk, n_rst, enable, clear_err;
  logic [7:0] number;
  logic [6:0] seg0, seg1;
  logic [1:0] sel0, sel1;
  logic dp0, dp1, fd0, fd1, err0, err1;
  int checks = 0;
  int fails = 0;
  bit cmp_on = 0;
  seven_seg_scanner #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BL), .ACTIVE_LOW(0), .BLANK_LEADING(1)) u_hi (
    .clk(clk), .n_rst(n_rst), .enable(enable), .number(number), .clear_err(clear_err),
    .seg(seg0), .dp(dp0), .digit_sel(sel0), .frame_done(fd0), .bcd_error(err0));
  seven_seg_scanner #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BL), .ACTIVE_LOW(1), .BLANK_LEADING(1)) u_lo (
    .clk(clk), .n_rst(n_rst), .enable(enable), .number(number), .clear_err(clear_err),
    .seg(seg1), .dp(dp1), .digit_sel(sel1), .frame_done(fd1), .bcd_error(err1));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask
  // model: scan position is simply the count of enabled edges since reset
  int p;
  logic [7:0] sh;
  logic [6:0] m_seg;
  logic [1:0] m_sel;
  logic m_fd, m_err;
  always @(posedge clk or negedge n_rst) begin : mdl
    int c, d;
    logic [3:0] v;
    bit on, blank;
    if (!n_rst) begin
      p <= 0; sh <= 0; m_seg <= 0; m_sel <= 0; m_fd <= 0; m_err <= 0;
    end else begin
      c = p % SD;
      d = (p / SD) % ND;
      v = sh[4*d +: 4];
      on = enable && c >= BL;
      blank = d > 0 && int'(sh) < (1 << (4*d));
      m_sel <= on ? 2'(1 << d) : 2'b00;
      m_seg <= on && !blank ? PAT[v] : 7'h00;
      m_fd <= enable && c == SD-1 && d == ND-1;
      m_err <= (on && v > 9) || (m_err && !clear_err);
      if (enable) begin
        if (c == SD-1 && d == ND-1) sh <= number;
        p <= p + 1;
      end
    end
  end
  always @(negedge clk) if (cmp_on) begin
    chk("seg", {1'b0, seg0}, {1'b0, m_seg});
    chk("sel", {6'b0, sel0}, {6'b0, m_sel});
    chk("dp", {7'b0, dp0}, 8'h00);
    chk("frame_done", {7'b0, fd0}, {7'b0, m_fd});
    chk("bcd_error", {7'b0, err0}, {7'b0, m_err});
    chk("seg_al", {1'b0, seg1}, {1'b0, ~m_seg});
    chk("sel_al", {6'b0, sel1}, {6'b0, ~m_sel});
    chk("dp_al", {7'b0, dp1}, 8'h01);
    chk("frame_done_al", {7'b0, fd1}, {7'b0, m_fd});
    chk("bcd_error_al", {7'b0, err1}, {7'b0, m_err});
  end
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic look(input string nm, input logic [1:0] s, input logic [6:0] g);
    chk({nm, "_sel"}, {6'b0, sel0}, {6'b0, s});
    chk({nm, "_seg"}, {1'b0, seg0}, {1'b0, g});
  endtask
  initial begin
    n_rst = 0; enable = 0; number = 0; clear_err = 0;
    step(2);
    look("rst", 2'b00, 7'h00);
    chk("rst_fd", {7'b0, fd0}, 8'h00);
    chk("rst_err", {7'b0, err0}, 8'h00);
    chk("rst_seg_al", {1'b0, seg1}, 8'h7F);
    chk("rst_sel_al", {6'b0, sel1}, 8'h03);
    chk("rst_dp_al", {7'b0, dp1}, 8'h01);
    cmp_on = 1;
    n_rst = 1; enable = 1; number = 8'h37;
    step(2);  look("f1_d0", 2'b01, 7'h3F);
    step(4);  look("f1_d1_blank", 2'b10, 7'h00);
    step(2);  chk("f1_done", {7'b0, fd0}, 8'h01);
    step(1);  chk("f1_done_end", {7'b0, fd0}, 8'h00); look("f2_gap", 2'b00, 7'h00);
    step(1);  look("f2_d0", 2'b01, 7'h07);
    step(4);  look("f2_d1", 2'b10, 7'h4F);
    number = 8'h12;
    step(4);  look("n12_d0", 2'b01, 7'h5B);
    number = 8'h45;
    step(4);  look("n12_d1_held", 2'b10, 7'h06);
    step(4);  look("n45_d0", 2'b01, 7'h6D);
    step(4);  look("n45_d1", 2'b10, 7'h66);
    number = 8'h0A;
    step(4);  look("dash", 2'b01, 7'h40); chk("err_set", {7'b0, err0}, 8'h01);
    clear_err = 1;
    step(1);  chk("err_set_wins", {7'b0, err0}, 8'h01);
    clear_err = 0; number = 8'h05;
    step(6);  chk("err_sticky", {7'b0, err0}, 8'h01);
    clear_err = 1;
    step(1);  chk("err_cleared", {7'b0, err0}, 8'h00); look("n05_d0", 2'b01, 7'h6D);
    clear_err = 0; enable = 0;
    step(1);  look("dis", 2'b00, 7'h00);
    step(9);  look("dis_hold", 2'b00, 7'h00); chk("dis_fd", {7'b0, fd0}, 8'h00);
    enable = 1;
    step(1);  look("resume_d0", 2'b01, 7'h6D);
    step(2);  look("resume_gap", 2'b00, 7'h00);
    step(1);  look("resume_d1_blank", 2'b10, 7'h00);
    step(2);  chk("resume_done", {7'b0, fd0}, 8'h01);
    number = 8'h99;
    step(10); look("n99_d0", 2'b01, 7'h6F);
    #2 n_rst = 0;
    #1 look("async_rst", 2'b00, 7'h00);
    chk("async_rst_seg_al", {1'b0, seg1}, 8'h7F);
    chk("async_rst_sel_al", {6'b0, sel1}, 8'h03);
    @(negedge clk) n_rst = 1;
    step(2);  look("post_rst_d0", 2'b01, 7'h3F);
    step(4);  look("post_rst_d1_blank", 2'b10, 7'h00);
    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
